alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALUSel produced by the ALU control unit, plus two N-bit operands.
- Returns a registered result with zero, negative and overflow flags to the EX/MEM boundary, using a valid/ready handshake on both sides.
- Logic and arithmetic ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, so no barrel shifter is needed; the unit back-pressures upstream while a shift is in progress.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_comb_core.sv | 44 ++++
 rtl/alu_exec_unit.sv | 141 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALUSel encoding and execute-unit state type; also used by the ALU control unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand-side and result-side valid/ready bundle of the execute-stage ALU.
interface alu_exec_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUSel;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         overflow;

  modport master (
    output in_valid, ALUSel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, negative, overflow
  );

  modport slave (
    input  in_valid, ALUSel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, negative, overflow
  );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational evaluator for all single-cycle ALU operations.
// Shift codes pass operand A through: they only reach here with a zero shift amount.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] value,
  output logic         overflow
);

  logic [N-1:0] sum;
  logic [N-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Operation select and signed-overflow detection
  always_comb begin
    value    = '0;
    overflow = 1'b0;
    case (sel)
      ALU_AND:  value = a & b;
      ALU_OR:   value = a | b;
      ALU_XOR:  value = a ^ b;
      ALU_ADD: begin
        value    = sum;
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        value    = diff;
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_SLL, ALU_SRL, ALU_SRA: value = a;
      ALU_SLT:  value = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: value = {{(N-1){1'b0}}, (a < b)};
      default:  value = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit-per-cycle shifts,
// registered result with zero/negative/overflow flags behind valid/ready handshakes.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  alu_exec_unit_if.slave  bus
);

  localparam int SHW = $clog2(N);

  alu_state_t   state_q, state_n;
  logic [N-1:0] acc_q, acc_n;
  logic [SHW-1:0] cnt_q, cnt_n;
  logic [3:0]   op_q, op_n;
  logic         out_valid_q, out_valid_n;
  logic [N-1:0] result_q, result_n;
  logic         zero_q, zero_n;
  logic         negative_q, negative_n;
  logic         overflow_q, overflow_n;

  logic [N-1:0]   core_value;
  logic           core_ovf;
  logic [SHW-1:0] shamt;
  logic [N-1:0]   shifted;
  logic           slot_free;
  logic           accept;

  alu_comb_core #(.N(N)) u_core (
    .sel      (bus.ALUSel),
    .a        (bus.op_a),
    .b        (bus.op_b),
    .value    (core_value),
    .overflow (core_ovf)
  );

  assign shamt     = bus.op_b[SHW-1:0];
  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state_q == ST_IDLE) && slot_free && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;

  // One-bit step of the latched shift op
  always_comb begin
    case (op_q)
      ALU_SLL: shifted = {acc_q[N-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, acc_q[N-1:1]};
      default: shifted = {acc_q[N-1], acc_q[N-1:1]};
    endcase
  end

  // Next-state, shift iteration and output-slot update; flush overrides accept/progress
  always_comb begin
    state_n     = state_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    op_n        = op_q;
    out_valid_n = out_valid_q && !bus.out_ready;
    result_n    = result_q;
    zero_n      = zero_q;
    negative_n  = negative_q;
    overflow_n  = overflow_q;

    if (flush) begin
      state_n     = ST_IDLE;
      out_valid_n = 1'b0;
      cnt_n       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift(bus.ALUSel) && (shamt != '0)) begin
              acc_n   = bus.op_a;
              cnt_n   = shamt;
              op_n    = bus.ALUSel;
              state_n = ST_SHIFT;
            end else begin
              out_valid_n = 1'b1;
              result_n    = core_value;
              zero_n      = (core_value == '0);
              negative_n  = core_value[N-1];
              overflow_n  = core_ovf;
            end
          end
        end
        ST_SHIFT: begin
          // The last step waits at cnt==1 until the output slot can take the value
          if (cnt_q != SHW'(1)) begin
            acc_n = shifted;
            cnt_n = cnt_q - SHW'(1);
          end else if (slot_free) begin
            acc_n       = shifted;
            cnt_n       = '0;
            state_n     = ST_IDLE;
            out_valid_n = 1'b1;
            result_n    = shifted;
            zero_n      = (shifted == '0);
            negative_n  = shifted[N-1];
            overflow_n  = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= ALU_AND;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      cnt_q       <= cnt_n;
      op_q        <= op_n;
      out_valid_q <= out_valid_n;
      result_q    <= result_n;
      zero_q      <= zero_n;
      negative_q  <= negative_n;
      overflow_q  <= overflow_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected {result,zero,negative,overflow}
// is queued on each accepted operation and compared when the DUT hands it over.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.N(32)) bus ();

  alu_exec_unit #(.N(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [34:0] sb[$];
  logic [34:0] last_popped = '0;
  bit          rand_ready = 1'b0;
  string       cur_tag = "init";

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model built from SV operators, independent of the iterative shifter
  function automatic logic [34:0] model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [32:0] wide;
    r = '0;
    v = 1'b0;
    case (sel)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_ADD: begin
        wide = {a[31], a} + {b[31], b};
        r = wide[31:0];
        v = wide[32] != wide[31];
      end
      ALU_SUB: begin
        wide = {a[31], a} - {b[31], b};
        r = wide[31:0];
        v = wide[32] != wide[31];
      end
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = '0;
    endcase
    return {r, (r == 32'd0), r[31], v};
  endfunction

  // Called just after a negedge with inputs set; samples, updates scoreboard, advances one cycle
  task automatic tick(output bit fired);
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    fired = bus.in_valid && bus.in_ready;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("pop_with_empty_scoreboard", 64'(bus.out_valid), 64'd0);
        end else begin
          last_popped = sb.pop_front();
          check_eq(cur_tag, 64'({bus.result, bus.zero, bus.negative, bus.overflow}), 64'(last_popped));
        end
      end
      if (fired) sb.push_back(model(bus.ALUSel, bus.op_a, bus.op_b));
      if (flush) sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    bit f;
    for (int unsigned i = 0; i < n; i++) tick(f);
  endtask

  task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    bit f;
    bus.in_valid = 1'b1;
    bus.ALUSel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    f = 1'b0;
    for (int unsigned i = 0; i < 100 && !f; i++) tick(f);
    check_eq("accept_within_budget", 64'(f), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 200 && sb.size() != 0; i++) tick(f);
    check_eq("drain_leftover", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    logic [3:0] ops3[3];
    logic [3:0] all_ops[12];
    ops3 = '{ALU_AND, ALU_OR, ALU_XOR};
    all_ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL,
                ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, 4'b1010, 4'b1111};

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.ALUSel = ALU_AND;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // Reset state
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_flags", 64'({bus.zero, bus.negative, bus.overflow}), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ADD overflow into the sign bit
    bus.out_ready = 1'b1;
    cur_tag = "add_ovf";
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check_eq("add_ovf_valid", 64'(bus.out_valid), 64'd1);
    check_eq("add_ovf_result", 64'(bus.result), 64'h8000_0000);
    check_eq("add_ovf_znv", 64'({bus.zero, bus.negative, bus.overflow}), 64'b011);
    drain();

    cur_tag = "sub_zero";
    send(ALU_SUB, 32'd5, 32'd5);
    check_eq("sub_zero_flags", 64'({bus.result, bus.zero, bus.overflow}), 64'b10);
    cur_tag = "slt";
    send(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    check_eq("slt_result", 64'(bus.result), 64'd1);
    cur_tag = "sltu";
    send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    check_eq("sltu_result", 64'(bus.result), 64'd0);
    drain();

    // SRA by 4: busy 4 cycles, result on the 5th edge
    cur_tag = "sra4";
    send(ALU_SRA, 32'h8000_0000, 32'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check_eq("sra4_busy_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("sra4_busy_out_valid", 64'(bus.out_valid), 64'd0);
      tick(f);
    end
    check_eq("sra4_done_valid", 64'(bus.out_valid), 64'd1);
    check_eq("sra4_done_result", 64'(bus.result), 64'hF800_0000);
    drain();

    // Zero shift amount completes in one cycle
    cur_tag = "sll0";
    send(ALU_SLL, 32'd1, 32'd0);
    check_eq("sll0_valid", 64'(bus.out_valid), 64'd1);
    check_eq("sll0_result", 64'(bus.result), 64'd1);
    drain();

    // Pending result held stable while downstream stalls; shift waits for the slot
    cur_tag = "hold_add";
    bus.out_ready = 1'b0;
    send(ALU_ADD, 32'd10, 32'd20);
    bus.in_valid = 1'b1;
    bus.ALUSel = ALU_SLL;
    bus.op_a = 32'd3;
    bus.op_b = 32'd2;
    for (int unsigned i = 0; i < 3; i++) begin
      tick(f);
      check_eq("hold_no_accept", 64'(f), 64'd0);
      check_eq("hold_result_stable", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'd30});
    end
    bus.out_ready = 1'b1;
    tick(f);
    check_eq("hold_accept_on_pop", 64'(f), 64'd1);
    bus.in_valid = 1'b0;
    cur_tag = "hold_sll";
    check_eq("hold_sll_busy0", 64'(bus.out_valid), 64'd0);
    tick(f);
    check_eq("hold_sll_busy1", 64'(bus.out_valid), 64'd0);
    tick(f);
    check_eq("hold_sll_result", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'h0000_000C});
    drain();

    // Back-to-back logic ops, one per cycle
    cur_tag = "b2b";
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      bus.ALUSel = ops3[i % 3];
      bus.op_a = $urandom();
      bus.op_b = $urandom();
      tick(f);
      check_eq("b2b_in_ready", 64'(f), 64'd1);
    end
    bus.in_valid = 1'b0;
    drain();

    // Same with toggling out_ready, then a random mix of every code
    cur_tag = "toggle";
    rand_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) send(ops3[i % 3], $urandom(), $urandom());
    drain();
    cur_tag = "mix";
    rand_ready = 1'b1;
    for (int unsigned i = 0; i < 40; i++)
      send(all_ops[$urandom_range(0, 11)], $urandom(), $urandom());
    drain();

    // Flush on the 3rd cycle of an SRL discards it and keeps the old result
    cur_tag = "flush";
    idle(2);
    send(ALU_SRL, 32'h0000_00F0, 32'd8);
    idle(1);
    flush = 1'b1;
    tick(f);
    flush = 1'b0;
    #1;
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("flush_result_kept", 64'({bus.result, bus.zero, bus.negative, bus.overflow}), 64'(last_popped));
    idle(12);
    check_eq("flush_no_stale", 64'(bus.out_valid), 64'd0);

    // Reset on the 2nd cycle of a shift
    cur_tag = "rst_mid";
    send(ALU_SLL, 32'd1, 32'd10);
    rst = 1'b1;
    tick(f);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_outputs", 64'({bus.out_valid, bus.result, bus.zero, bus.negative, bus.overflow}), 64'd0);
    check_eq("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    idle(15);
    check_eq("rst_mid_no_result", 64'(bus.out_valid), 64'd0);

    cur_tag = "post_rst";
    send(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
